// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt path: the iterative FSM state type and the
// inverse round transforms applied to a 128-bit state (byte i = bits [127-8i -: 8], column-major).
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_iter_state_t;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates right by r columns: byte (r,c) moves to (r,(c+r)%4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * ((c + r) % 4) + r) -: 8] = s[127 - 8 * (4 * c + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8 * (4 * c + r) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 8 * (4 * c + 0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127 - 8 * (4 * c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127 - 8 * (4 * c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127 - 8 * (4 * c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round in the equivalent-key-free order:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] keyed;

    assign keyed     = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;
    assign state_out = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, walking the encryption key schedule
// backwards from key[NR] to key[0], with valid/ready handshakes on both sides.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  rkey [4*(NR+1)],
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    localparam int RW = $clog2(NR);

    logic [127:0]    round_keys [NR+1];
    aes_iter_state_t fsm_reg;
    logic [RW-1:0]   rnd_reg;
    logic [127:0]    state_reg;
    logic [127:0]    round_out;
    logic            out_valid_reg;
    logic            idle_ready_reg;
    logic            accept;

    for (genvar gi = 0; gi <= NR; gi++) begin : g_round_key
        assign round_keys[gi] = {rkey[4*gi+3], rkey[4*gi+2], rkey[4*gi+1], rkey[4*gi]};
    end

    aes_inv_round u_round (
        .state_in  (state_reg),
        .round_key (round_keys[rnd_reg]),
        .last      (rnd_reg == '0),
        .state_out (round_out)
    );

    // idle_ready_reg keeps in_ready low until the first edge after reset release.
    assign in_ready  = ((fsm_reg == IDLE) && idle_ready_reg) || ((fsm_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign pt        = state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg        <= IDLE;
            rnd_reg        <= '0;
            state_reg      <= '0;
            out_valid_reg  <= 1'b0;
            idle_ready_reg <= 1'b0;
        end else begin
            idle_ready_reg <= 1'b1;
            case (fsm_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= ct ^ round_keys[NR];
                        rnd_reg   <= RW'(NR - 1);
                        fsm_reg   <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (rnd_reg == '0) begin
                        fsm_reg       <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        rnd_reg <= rnd_reg - RW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (in_valid) begin
                            state_reg <= ct ^ round_keys[NR];
                            rnd_reg   <= RW'(NR - 1);
                            fsm_reg   <= ROUND;
                        end else begin
                            fsm_reg <= IDLE;
                        end
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128 and AES-256 instances checked against a forward-cipher
// model (S-box derived from GF(2^8) inversion) using known vectors and random blocks.
module tb_aes_inv_cipher_iter;

    localparam int NR_A = 10;
    localparam int NR_B = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic         a_in_ready, a_out_valid;
    logic [127:0] a_ct = '0, a_pt;
    logic [31:0]  a_rkey [4*(NR_A+1)];

    logic         b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic         b_in_ready, b_out_valid;
    logic [127:0] b_ct = '0, b_pt;
    logic [31:0]  b_rkey [4*(NR_B+1)];

    logic [7:0]   sbox_t [256];
    logic [31:0]  w_a [60];
    logic [31:0]  w_b [60];
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NK(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rkey(a_rkey), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .ct(a_ct), .out_valid(a_out_valid), .out_ready(a_out_ready), .pt(a_pt)
    );

    aes_inv_cipher_iter #(.NK(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .rkey(b_rkey), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ct(b_ct), .out_valid(b_out_valid), .out_ready(b_out_ready), .pt(b_pt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Forward FIPS-197 cipher on a byte array; the DUT must invert it.
    function automatic logic [127:0] enc(input logic [127:0] p, input int sel);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        int           nr;
        if (sel != 0) w = w_b; else w = w_a;
        nr = (sel != 0) ? NR_B : NR_A;
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[4 * (((i / 4) + (i % 4)) % 4) + (i % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // Key expansion; key words are taken MSB-first from the 256-bit argument.
    task automatic load_key(input int sel, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        int          nk, nr;
        nk = (sel != 0) ? 8 : 4;
        nr = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        if (sel != 0) begin
            w_b = w;
            for (int r = 0; r <= NR_B; r++) for (int j = 0; j < 4; j++) b_rkey[4*r+j] = w[4*r+3-j];
        end else begin
            w_a = w;
            for (int r = 0; r <= NR_A; r++) for (int j = 0; j < 4; j++) a_rkey[4*r+j] = w[4*r+3-j];
        end
    endtask

    // Offer a block; returns half a cycle after the accepting edge.
    task automatic send(input int sel, input logic [127:0] c);
        bit ok;
        ok = 1'b0;
        if (sel != 0) begin b_ct = c; b_in_valid = 1'b1; end
        else begin a_ct = c; a_in_valid = 1'b1; end
        for (int k = 0; k < 60 && !ok; k++) begin
            ok = (sel != 0) ? b_in_ready : a_in_ready;
            @(negedge clk);
        end
        if (sel != 0) b_in_valid = 1'b0; else a_in_valid = 1'b0;
        check("accept", 128'(ok), 128'(1));
    endtask

    // lat counts clock edges since the accept edge until out_valid is seen.
    task automatic wait_out(input int sel, input int start, output int lat);
        lat = start;
        while (!((sel != 0) ? b_out_valid : a_out_valid) && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, seen, n_acc, n_out;
        bit           acc, outp;
        logic [127:0] p0, p1, c;
        logic [127:0] sp [4];
        int           acc_cyc [4];

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        load_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        load_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(a_in_ready), 128'(0));
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_pt", a_pt, 128'h0);
        check("rst_b_out_valid", 128'(b_out_valid), 128'(0));
        rst_n = 1'b1;
        #1 check("rel_in_ready_pre_edge", 128'(a_in_ready), 128'(0));
        @(negedge clk);
        check("rel_in_ready", 128'(a_in_ready), 128'(1));
        check("rel_b_in_ready", 128'(b_in_ready), 128'(1));

        // FIPS-197 appendix B
        send(0, 128'h3925841d02dc09fbdc118597196a0b32);
        wait_out(0, 0, lat);
        check("fips_b_lat", 128'(lat), 128'(10));
        check("fips_b_pt", a_pt, 128'h3243f6a8885a308d313198a2e0370734);
        $display("blk fips_b pt=%h lat=%0d", a_pt, lat);
        @(negedge clk);
        check("fips_b_one_pulse", 128'(a_out_valid), 128'(0));

        // FIPS-197 C.1 and C.3
        load_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        wait_out(0, 0, lat);
        check("fips_c1_lat", 128'(lat), 128'(10));
        check("fips_c1_pt", a_pt, 128'h00112233445566778899aabbccddeeff);
        $display("blk fips_c1 pt=%h lat=%0d", a_pt, lat);
        @(negedge clk);
        send(1, 128'h8ea2b7ca516745bfeafc49904b496089);
        wait_out(1, 0, lat);
        check("fips_c3_lat", 128'(lat), 128'(14));
        check("fips_c3_pt", b_pt, 128'h00112233445566778899aabbccddeeff);
        $display("blk fips_c3 pt=%h lat=%0d", b_pt, lat);
        @(negedge clk);

        // Random AES-256 block
        load_key(1, {rand128(), rand128()});
        p0 = rand128();
        send(1, enc(p0, 1));
        wait_out(1, 0, lat);
        check("rand256_pt", b_pt, p0);
        $display("blk rand256 pt=%h lat=%0d", b_pt, lat);
        @(negedge clk);

        // Backpressure, then consume and accept on the same edge
        load_key(0, {rand128(), 128'h0});
        p0 = rand128();
        p1 = rand128();
        a_out_ready = 1'b0;
        send(0, enc(p0, 0));
        wait_out(0, 0, lat);
        check("bp_lat", 128'(lat), 128'(10));
        a_ct = enc(p1, 0);
        a_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_valid%0d", k), 128'(a_out_valid), 128'(1));
            check($sformatf("bp_hold_pt%0d", k), a_pt, p0);
            check($sformatf("bp_hold_in_ready%0d", k), 128'(a_in_ready), 128'(0));
            @(negedge clk);
        end
        $display("blk bp0 pt=%h", a_pt);
        a_out_ready = 1'b1;
        #1 check("bp_release_in_ready", 128'(a_in_ready), 128'(1));
        @(negedge clk);
        a_in_valid = 1'b0;
        check("bp_consumed", 128'(a_out_valid), 128'(0));
        check("bp_busy_in_ready", 128'(a_in_ready), 128'(0));
        wait_out(0, 0, lat);
        check("bp_next_lat", 128'(lat), 128'(10));
        check("bp_next_pt", a_pt, p1);
        $display("blk bp1 pt=%h lat=%0d", a_pt, lat);
        @(negedge clk);

        // Streaming four blocks with in_valid held high
        for (int k = 0; k < 4; k++) begin
            sp[k] = rand128();
            acc_cyc[k] = 0;
        end
        n_acc = 0;
        n_out = 0;
        a_ct = enc(sp[0], 0);
        a_in_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && n_out < 4; cyc++) begin
            acc  = a_in_valid && a_in_ready;
            outp = a_out_valid && a_out_ready;
            if (outp) begin
                check($sformatf("stream_pt%0d", n_out), a_pt, sp[n_out]);
                $display("blk stream%0d pt=%h cyc=%0d", n_out, a_pt, cyc);
                n_out++;
            end
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            if (acc) begin
                if (n_acc < 4) a_ct = enc(sp[n_acc], 0);
                else a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0;
        check("stream_count", 128'(n_out), 128'(4));
        for (int k = 1; k < 4; k++) begin
            check($sformatf("stream_period%0d", k), 128'(acc_cyc[k] - acc_cyc[k-1]), 128'(11));
        end

        // in_valid pulsed while busy must be ignored
        p0 = rand128();
        send(0, enc(p0, 0));
        repeat (3) @(negedge clk);
        a_ct = enc(rand128(), 0);
        a_in_valid = 1'b1;
        check("busy_in_ready", 128'(a_in_ready), 128'(0));
        repeat (2) @(negedge clk);
        a_in_valid = 1'b0;
        a_ct = '0;
        wait_out(0, 5, lat);
        check("busy_lat", 128'(lat), 128'(10));
        check("busy_pt", a_pt, p0);
        $display("blk busy pt=%h lat=%0d", a_pt, lat);
        @(negedge clk);
        check("busy_drop", 128'(a_out_valid), 128'(0));
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("busy_ignored", 128'(seen), 128'(0));

        // Reset during round 5
        send(0, enc(rand128(), 0));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(a_out_valid), 128'(0));
        check("midrst_pt", a_pt, 128'h0);
        check("midrst_in_ready", 128'(a_in_ready), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_rel_in_ready", 128'(a_in_ready), 128'(0));
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("midrst_no_stale", 128'(seen), 128'(0));
        check("midrst_in_ready_after", 128'(a_in_ready), 128'(1));
        p0 = rand128();
        send(0, enc(p0, 0));
        wait_out(0, 0, lat);
        check("midrst_fresh_lat", 128'(lat), 128'(10));
        check("midrst_fresh_pt", a_pt, p0);
        $display("blk fresh pt=%h lat=%0d", a_pt, lat);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
